board_eliminator: RTL and testbench

BOARD_ELIMINATOR -- requirements
Module: board_eliminator

---
 rtl/ttt_pkg.sv | 40 ++++
 rtl/mark_fifo.sv | 48 ++++
 rtl/board_eliminator.sv | 127 ++++++++++++
 tb/tb_board_eliminator.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: mark encodings, board geometry and the win-line table.
package ttt_pkg;
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        O     = 2'b01,
        X     = 2'b10
    } mark_e;

    localparam int NUM_CELLS = 9;
    localparam int MAX_MARKS = 3;

    // Cell-index triples; index 0..2 rows, 3..5 columns, 6..7 diagonals.
    localparam logic [7:0][2:0][3:0] WIN_LINES = {
        {4'd2, 4'd4, 4'd6},
        {4'd0, 4'd4, 4'd8},
        {4'd2, 4'd5, 4'd8},
        {4'd1, 4'd4, 4'd7},
        {4'd0, 4'd3, 4'd6},
        {4'd6, 4'd7, 4'd8},
        {4'd3, 4'd4, 4'd5},
        {4'd0, 4'd1, 4'd2}
    };

    // X wins ties; both holding a line cannot happen in legal play.
    function automatic logic [1:0] eval_winner(input logic [NUM_CELLS-1:0][1:0] b);
        logic x_win;
        logic o_win;
        x_win = 1'b0;
        o_win = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (b[WIN_LINES[i][0]] == X && b[WIN_LINES[i][1]] == X && b[WIN_LINES[i][2]] == X)
                x_win = 1'b1;
            if (b[WIN_LINES[i][0]] == O && b[WIN_LINES[i][1]] == O && b[WIN_LINES[i][2]] == O)
                o_win = 1'b1;
        end
        if (x_win)      return X;
        else if (o_win) return O;
        else            return EMPTY;
    endfunction
endpackage

// File: rtl/mark_fifo.sv
// Age-ordered list of one player's occupied cells; head is the oldest entry.
module mark_fifo
    import ttt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [3:0] din_i,
    output logic [3:0] head_o,
    output logic [1:0] count_o
);
    logic [2:0][3:0] ent_q, ent_d;
    logic [1:0]      cnt_q, cnt_d;

    always_comb begin
        ent_d = ent_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            ent_d = '0;
            cnt_d = '0;
        end else begin
            // Pop first so a full list can take a push in the same cycle.
            if (pop_i && cnt_q != 2'd0) begin
                ent_d = {4'h0, ent_q[2], ent_q[1]};
                cnt_d = cnt_q - 2'd1;
            end
            if (push_i && cnt_d != 2'(MAX_MARKS)) begin
                ent_d[cnt_d] = din_i;
                cnt_d        = cnt_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_q <= '0;
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = ent_q[0];
    assign count_o = cnt_q;
endmodule

// File: rtl/board_eliminator.sv
// Tic-tac-toe board where each player keeps at most three marks; a fourth evicts the oldest.
module board_eliminator
    import ttt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [3:0] location,
    input  logic [1:0] mark,
    input  logic       whosTurn,
    output logic [1:0] a0,
    output logic [1:0] a1,
    output logic [1:0] a2,
    output logic [1:0] a3,
    output logic [1:0] a4,
    output logic [1:0] a5,
    output logic [1:0] a6,
    output logic [1:0] a7,
    output logic [1:0] a8,
    output logic [1:0] winner,
    output logic       game_over,
    output logic [3:0] removed_loc,
    output logic       removed_stb
);
    logic                       turn_q;
    logic [NUM_CELLS-1:0][1:0]  board_q, board_d;
    logic [1:0]                 winner_q, winner_d;
    logic                       go_q, go_d;
    logic [3:0]                 rloc_q, rloc_d;
    logic                       rstb_q, rstb_d;

    logic       move_evt, mark_ok, loc_ok, accept, is_x, evict;
    logic [3:0] loc_idx, x_head, o_head, evict_loc;
    logic [1:0] x_cnt, o_cnt, line_win;

    assign move_evt = (whosTurn != turn_q);
    assign mark_ok  = (mark == X) || (mark == O);
    assign loc_ok   = (location <= 4'd8);
    assign loc_idx  = loc_ok ? location : 4'd0;
    assign accept   = move_evt && mark_ok && loc_ok && (board_q[loc_idx] == EMPTY)
                      && !go_q && !clear;
    assign is_x      = (mark == X);
    assign evict     = accept && (is_x ? (x_cnt == 2'(MAX_MARKS)) : (o_cnt == 2'(MAX_MARKS)));
    assign evict_loc = is_x ? x_head : o_head;
    assign line_win  = eval_winner(board_q);

    mark_fifo u_fifo_x (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clear),
        .push_i  (accept && is_x),
        .pop_i   (evict && is_x),
        .din_i   (loc_idx),
        .head_o  (x_head),
        .count_o (x_cnt)
    );

    mark_fifo u_fifo_o (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clear),
        .push_i  (accept && !is_x),
        .pop_i   (evict && !is_x),
        .din_i   (loc_idx),
        .head_o  (o_head),
        .count_o (o_cnt)
    );

    always_comb begin
        board_d  = board_q;
        winner_d = winner_q;
        go_d     = go_q;
        rloc_d   = rloc_q;
        rstb_d   = 1'b0;
        if (clear) begin
            board_d  = '0;
            winner_d = EMPTY;
            go_d     = 1'b0;
            rloc_d   = '0;
        end else begin
            // The new cell is empty, so it never aliases the evicted (occupied) cell.
            if (evict) begin
                board_d[evict_loc] = EMPTY;
                rloc_d             = evict_loc;
                rstb_d             = 1'b1;
            end
            if (accept)
                board_d[loc_idx] = mark;
            if (!go_q && line_win != EMPTY) begin
                winner_d = line_win;
                go_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            turn_q   <= 1'b0;
            board_q  <= '0;
            winner_q <= EMPTY;
            go_q     <= 1'b0;
            rloc_q   <= '0;
            rstb_q   <= 1'b0;
        end else begin
            turn_q   <= whosTurn;
            board_q  <= board_d;
            winner_q <= winner_d;
            go_q     <= go_d;
            rloc_q   <= rloc_d;
            rstb_q   <= rstb_d;
        end
    end

    assign a0          = board_q[0];
    assign a1          = board_q[1];
    assign a2          = board_q[2];
    assign a3          = board_q[3];
    assign a4          = board_q[4];
    assign a5          = board_q[5];
    assign a6          = board_q[6];
    assign a7          = board_q[7];
    assign a8          = board_q[8];
    assign winner      = winner_q;
    assign game_over   = go_q;
    assign removed_loc = rloc_q;
    assign removed_stb = rstb_q;
endmodule

// File: tb/tb_board_eliminator.sv
// Directed bench for board_eliminator with hand-computed board states.
module tb_board_eliminator;
    logic       clk = 1'b0;
    logic       rst, clear, whosTurn;
    logic [3:0] location;
    logic [1:0] mark;
    logic [1:0] a0, a1, a2, a3, a4, a5, a6, a7, a8, winner;
    logic       game_over, removed_stb;
    logic [3:0] removed_loc;

    int n_assert = 0;
    int n_fail   = 0;

    logic [8:0][1:0] exp_b;
    logic [8:0][1:0] obs_b;

    localparam logic [1:0] MX = 2'b10;
    localparam logic [1:0] MO = 2'b01;

    always #5 clk = ~clk;

    board_eliminator dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .location    (location),
        .mark        (mark),
        .whosTurn    (whosTurn),
        .a0          (a0),
        .a1          (a1),
        .a2          (a2),
        .a3          (a3),
        .a4          (a4),
        .a5          (a5),
        .a6          (a6),
        .a7          (a7),
        .a8          (a8),
        .winner      (winner),
        .game_over   (game_over),
        .removed_loc (removed_loc),
        .removed_stb (removed_stb)
    );

    assign obs_b = {a8, a7, a6, a5, a4, a3, a2, a1, a0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Present a move as a whosTurn toggle, then sample just after the edge that applies it.
    task automatic move(input logic [3:0] loc, input logic [1:0] mk);
        @(negedge clk);
        location = loc;
        mark     = mk;
        whosTurn = ~whosTurn;
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; whosTurn = 1'b0; location = 4'd0; mark = 2'b00;
        #12;
        chk("reset_board", 32'(obs_b), 32'd0);
        chk("reset_winner", 32'(winner), 32'd0);
        chk("reset_game_over", 32'(game_over), 32'd0);
        chk("reset_removed", 32'({removed_loc, removed_stb}), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single legal move lands one cycle after the toggle.
        move(4'd4, MX);
        exp_b = '0; exp_b[4] = MX;
        chk("first_move_board", 32'(obs_b), 32'(exp_b));
        chk("first_move_no_stb", 32'(removed_stb), 32'd0);

        // O onto X's occupied cell, then invalid mark and out-of-range location.
        move(4'd4, MO);
        chk("occupied_reject", 32'(obs_b), 32'(exp_b));
        chk("occupied_no_stb", 32'(removed_stb), 32'd0);
        move(4'd0, 2'b00);
        chk("none_mark_reject", 32'(obs_b), 32'(exp_b));
        move(4'd9, MO);
        chk("loc9_reject", 32'(obs_b), 32'(exp_b));

        do_clear();
        chk("clear_board", 32'(obs_b), 32'd0);

        // Fourth X evicts X's oldest cell (0) in the same update.
        move(4'd0, MX); move(4'd3, MO);
        move(4'd1, MX); move(4'd7, MO);
        move(4'd5, MX); move(4'd8, MO);
        exp_b = '0;
        exp_b[0] = MX; exp_b[1] = MX; exp_b[5] = MX;
        exp_b[3] = MO; exp_b[7] = MO; exp_b[8] = MO;
        chk("six_marks_board", 32'(obs_b), 32'(exp_b));
        chk("six_marks_no_stb", 32'(removed_stb), 32'd0);
        move(4'd2, MX);
        exp_b[0] = 2'b00; exp_b[2] = MX;
        chk("evict_board", 32'(obs_b), 32'(exp_b));
        chk("evict_stb", 32'(removed_stb), 32'd1);
        chk("evict_loc", 32'(removed_loc), 32'd0);
        tick();
        chk("evict_stb_pulse", 32'(removed_stb), 32'd0);
        chk("evict_loc_held", 32'(removed_loc), 32'd0);
        chk("evict_no_winner", 32'({winner, game_over}), 32'd0);

        // Fourth O evicts O's oldest (3).
        move(4'd6, MO);
        exp_b[3] = 2'b00; exp_b[6] = MO;
        chk("evict_o_board", 32'(obs_b), 32'(exp_b));
        chk("evict_o_loc", 32'({removed_loc, removed_stb}), 32'h7);

        // X diagonal 0,4,8 wins two cycles after the last move.
        do_clear();
        move(4'd0, MX); move(4'd1, MO);
        move(4'd4, MX); move(4'd2, MO);
        move(4'd8, MX);
        chk("win_one_cycle", 32'({winner, game_over}), 32'd0);
        tick();
        chk("win_winner", 32'(winner), 32'(MX));
        chk("win_game_over", 32'(game_over), 32'd1);
        exp_b = '0;
        exp_b[0] = MX; exp_b[4] = MX; exp_b[8] = MX; exp_b[1] = MO; exp_b[2] = MO;
        move(4'd3, MO);
        chk("frozen_board", 32'(obs_b), 32'(exp_b));
        tick();
        chk("win_latched", 32'({winner, game_over}), 32'({MX, 1'b1}));

        // Clear beats a simultaneous move.
        @(negedge clk);
        clear = 1'b1; location = 4'd5; mark = MX; whosTurn = ~whosTurn;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clear_vs_move_board", 32'(obs_b), 32'd0);
        chk("clear_vs_move_win", 32'({winner, game_over}), 32'd0);
        tick();
        chk("clear_move_dropped", 32'(obs_b), 32'd0);

        // Reset mid-game with five marks placed.
        move(4'd0, MX); move(4'd1, MO);
        move(4'd2, MX); move(4'd3, MO);
        move(4'd4, MX);
        exp_b = '0;
        exp_b[0] = MX; exp_b[2] = MX; exp_b[4] = MX; exp_b[1] = MO; exp_b[3] = MO;
        chk("five_marks_board", 32'(obs_b), 32'(exp_b));
        #2;
        rst = 1'b0; whosTurn = 1'b0;
        #1;
        chk("mid_reset_board", 32'(obs_b), 32'd0);
        chk("mid_reset_outputs", 32'({winner, game_over, removed_loc, removed_stb}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post_reset_idle", 32'(obs_b), 32'd0);
        move(4'd5, MX);
        exp_b = '0; exp_b[5] = MX;
        chk("post_reset_move", 32'(obs_b), 32'(exp_b));
        chk("post_reset_no_stb", 32'(removed_stb), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
